// File: rtl/lotr_pkg.sv
// lotr_pkg: shared types and constants for the terminal UART receive path
package lotr_pkg;
  typedef enum logic [1:0] {TERM_W, TERM_R, TERM_JB, TERM_MB} t_term_op;
  localparam logic [7:0] TERM_OP_W = 8'h57;
  localparam logic [7:0] TERM_OP_R = 8'h52;
  localparam logic [7:0] TERM_OP_J = 8'h4A;
  localparam logic [7:0] TERM_OP_M = 8'h4D;
  typedef enum logic [2:0] {ST_OP, ST_ADDR, ST_SIZE, ST_DATA, ST_ISSUE} t_term_st;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} t_rx_st;
endpackage

// File: rtl/lotr_uart_term_rx_if.sv
// lotr_uart_term_rx_if: single-word memory request channel toward the fabric
interface lotr_uart_term_rx_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  modport master (output req_valid, req_wr, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_wr, req_addr, req_data, output req_ready);
endinterface

// File: rtl/lotr_uart_rx_byte.sv
// lotr_uart_rx_byte: 8N1 deserializer with input sync, mid-bit sampling and frame check
module lotr_uart_rx_byte
  import lotr_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       QClk,
  input  logic       RstQnnnH,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err
);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  t_rx_st      st_q, st_d;
  logic [1:0]  sync_q, sync_d;
  logic        armed_q, armed_d, vld_q, vld_d, ferr_q, ferr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        rx, tick;
  assign rx        = sync_q[1];
  assign tick      = cnt_q == LAST;
  assign rx_byte   = sh_q;
  assign byte_vld  = vld_q;
  assign frame_err = ferr_q;
  always_comb begin
    st_d    = st_q;
    sync_d  = {sync_q[0], uart_rx};
    armed_d = armed_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d   = '0;
        armed_d = armed_q | rx;
        // only a high-to-low transition after seeing idle counts as a start bit
        if (armed_q && !rx) begin
          st_d    = RX_START;
          armed_d = 1'b0;
        end
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        st_d  = rx ? RX_IDLE : RX_BITS;
      end
      RX_BITS: if (tick) begin
        cnt_d = '0;
        sh_d  = {rx, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        st_d  = bit_q == 3'd7 ? RX_STOP : RX_BITS;
      end
      default: if (tick) begin
        st_d   = RX_IDLE;
        vld_d  = rx;
        ferr_d = !rx;
      end
    endcase
  end
  always_ff @(posedge QClk or posedge RstQnnnH)
    if (RstQnnnH) begin
      st_q    <= RX_IDLE;
      sync_q  <= '0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      sync_q  <= sync_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
endmodule

// File: rtl/lotr_uart_term_rx.sv
// lotr_uart_term_rx: UART terminal command parser producing single-word memory requests
module lotr_uart_term_rx
  import lotr_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUDRATE    = 115200
) (
  input  logic                   QClk,
  input  logic                   RstQnnnH,
  input  logic                   uart_rx,
  lotr_uart_term_rx_if.master    req,
  output logic                   frame_err,
  output logic                   cmd_err,
  output logic                   overrun_err
);
  logic [7:0]  rx_byte, hold_q, hold_d;
  logic        rx_vld, hold_vld_q, hold_vld_d, consume, known, valid;
  logic        cmd_err_q, cmd_err_d, ovr_q, ovr_d;
  t_term_st    st_q, st_d;
  t_term_op    op_q, op_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d, addr_q, addr_d, data_q, data_d, word;
  logic [29:0] words_q, words_d;
  lotr_uart_rx_byte #(.CLKS_PER_BIT(CLK_FREQ_HZ / BAUDRATE)) u_rx (
    .QClk(QClk), .RstQnnnH(RstQnnnH), .uart_rx(uart_rx),
    .rx_byte(rx_byte), .byte_vld(rx_vld), .frame_err(frame_err)
  );
  assign valid         = st_q == ST_ISSUE;
  assign req.req_valid = valid;
  assign req.req_wr    = valid && (op_q == TERM_W || op_q == TERM_JB);
  assign req.req_addr  = addr_q;
  assign req.req_data  = req.req_wr ? data_q : '0;
  assign cmd_err       = cmd_err_q;
  assign overrun_err   = ovr_q;
  assign consume       = hold_vld_q && st_q != ST_ISSUE;
  assign word          = {sh_q[23:0], hold_q};
  assign known         = hold_q inside {TERM_OP_W, TERM_OP_R, TERM_OP_J, TERM_OP_M};
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q & ~consume;
    ovr_d      = 1'b0;
    cmd_err_d  = 1'b0;
    st_d       = st_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    addr_d     = addr_q;
    data_d     = data_q;
    words_d    = words_q;
    // a slot freed this cycle can take the incoming byte
    if (rx_vld) begin
      ovr_d      = hold_vld_q && !consume;
      hold_d     = ovr_d ? hold_q : rx_byte;
      hold_vld_d = 1'b1;
    end
    if (consume) begin
      sh_d  = word;
      cnt_d = cnt_q + 2'd1;
    end
    case (st_q)
      ST_OP: if (consume) begin
        cnt_d     = '0;
        cmd_err_d = !known;
        st_d      = known ? ST_ADDR : ST_OP;
        op_d      = hold_q == TERM_OP_W ? TERM_W : hold_q == TERM_OP_R ? TERM_R :
                    hold_q == TERM_OP_J ? TERM_JB : TERM_MB;
      end
      ST_ADDR: if (consume && cnt_q == 2'd3) begin
        addr_d = word;
        st_d   = op_q == TERM_W ? ST_DATA : op_q == TERM_R ? ST_ISSUE : ST_SIZE;
      end
      ST_SIZE: if (consume && cnt_q == 2'd3) begin
        words_d = word[31:2];
        st_d    = word[31:2] == '0 ? ST_OP : op_q == TERM_JB ? ST_DATA : ST_ISSUE;
      end
      ST_DATA: if (consume && cnt_q == 2'd3) begin
        data_d = word;
        st_d   = ST_ISSUE;
      end
      default: if (req.req_ready) begin
        addr_d  = (op_q == TERM_W || op_q == TERM_R) ? addr_q : addr_q + 32'd4;
        words_d = words_q - 30'd1;
        st_d    = (op_q == TERM_W || op_q == TERM_R || words_q == 30'd1) ? ST_OP :
                  op_q == TERM_JB ? ST_DATA : ST_ISSUE;
      end
    endcase
  end
  always_ff @(posedge QClk or posedge RstQnnnH)
    if (RstQnnnH) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      ovr_q      <= 1'b0;
      cmd_err_q  <= 1'b0;
      st_q       <= ST_OP;
      op_q       <= TERM_W;
      cnt_q      <= '0;
      sh_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      words_q    <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      ovr_q      <= ovr_d;
      cmd_err_q  <= cmd_err_d;
      st_q       <= st_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      words_q    <= words_d;
    end
endmodule

// File: tb/tb_lotr_uart_term_rx.sv
// tb_lotr_uart_term_rx: table-driven and randomized command checks against a request-list model
`timescale 1ns/1ps
module tb_lotr_uart_term_rx;
  import lotr_pkg::*;
  localparam int CPB    = 16;
  localparam int BAUD   = 115200;
  localparam int CLK_HZ = CPB * BAUD;
  typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} req_t;
  typedef struct {logic [7:0] op; logic [31:0] addr; logic [31:0] size; logic [31:0] d0; int stall; int exp_n;} vec_t;
  logic clk = 0, rst = 1, rx = 0;
  logic ferr, cerr, oerr;
  req_t exp_q[$];
  logic [31:0] dq[$];
  vec_t tbl[8];
  int n_chk = 0, n_fail = 0, hs_cnt = 0, n_ferr = 0, n_cerr = 0, n_oerr = 0;
  lotr_uart_term_rx_if bus();
  lotr_uart_term_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUDRATE(BAUD)) dut (
    .QClk(clk), .RstQnnnH(rst), .uart_rx(rx), .req(bus.master),
    .frame_err(ferr), .cmd_err(cerr), .overrun_err(oerr)
  );
  always #271 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    n_ferr += int'(ferr);
    n_cerr += int'(cerr);
    n_oerr += int'(oerr);
    if (bus.req_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_req: got addr %0h with no expected request", bus.req_addr);
      end else begin
        chk("req_wr", 64'(bus.req_wr), 64'(exp_q[0].wr));
        chk("req_addr", 64'(bus.req_addr), 64'(exp_q[0].addr));
        chk("req_data", 64'(bus.req_data), 64'(exp_q[0].data));
        if (bus.req_ready) begin
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
    if (!stop) tick(CPB);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask
  // model: the list of requests a command must produce, from its opcode, address, size and payload
  function automatic void expect_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] size);
    if (op == TERM_OP_W) exp_q.push_back({1'b1, addr, dq[0]});
    if (op == TERM_OP_R) exp_q.push_back({1'b0, addr, 32'h0});
    if (op == TERM_OP_J || op == TERM_OP_M)
      for (int i = 0; i < int'(size / 4); i++)
        exp_q.push_back({op == TERM_OP_J, addr + 32'(4 * i), op == TERM_OP_J ? dq[i] : 32'h0});
  endfunction
  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] size);
    send_byte(op);
    send_word(addr);
    if (op == TERM_OP_J || op == TERM_OP_M) send_word(size);
    if (op == TERM_OP_W) send_word(dq[0]);
    if (op == TERM_OP_J) for (int i = 0; i < int'(size / 4); i++) send_word(dq[i]);
  endtask
  task automatic fill_data(input logic [31:0] d0, input int n);
    dq.delete();
    dq.push_back(d0);
    for (int i = 1; i < n; i++) dq.push_back($urandom);
  endtask
  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || bus.req_valid) && t < 3000) begin
      tick(1);
      t++;
    end
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask
  task automatic wait_valid(input string name);
    int t = 0;
    while (!bus.req_valid && t < 3000) begin
      tick(1);
      t++;
    end
    chk({name, "_valid_seen"}, 64'(bus.req_valid), 64'd1);
  endtask
  task automatic chk_idle_outputs(input string name);
    chk({name, "_valid"}, 64'(bus.req_valid), 64'd0);
    chk({name, "_wr"}, 64'(bus.req_wr), 64'd0);
    chk({name, "_addr"}, 64'(bus.req_addr), 64'd0);
    chk({name, "_data"}, 64'(bus.req_data), 64'd0);
    chk({name, "_errs"}, 64'({ferr, cerr, oerr}), 64'd0);
  endtask
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    exp_q.delete();
  endtask
  initial begin
    int h0, c0, f0, o0, words;
    logic [7:0] ops[4];
    logic [7:0] op;
    logic [31:0] addr, size;
    ops = '{TERM_OP_W, TERM_OP_R, TERM_OP_J, TERM_OP_M};
    tbl[0] = '{TERM_OP_W, 32'h03d02018, 32'd0,  32'hDEADBEEF, 0, 1};
    tbl[1] = '{TERM_OP_R, 32'h03d02018, 32'd0,  32'h0,        0, 1};
    tbl[2] = '{TERM_OP_J, 32'h03d02000, 32'hC,  32'h01020304, 0, 3};
    tbl[3] = '{TERM_OP_M, 32'h03d02000, 32'hC,  32'h0,        5, 3};
    tbl[4] = '{TERM_OP_M, 32'h03d02000, 32'hE,  32'h0,        0, 3};
    tbl[5] = '{TERM_OP_J, 32'h00001000, 32'h0,  32'h0,        0, 0};
    tbl[6] = '{TERM_OP_M, 32'hFFFFFFF8, 32'h10, 32'h0,        3, 4};
    tbl[7] = '{TERM_OP_W, 32'h00000003, 32'd0,  32'h12345678, 0, 1};
    bus.req_ready = 1'b1;
    tick(5);
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick(60);
    rx = 1'b1;
    tick(60);
    chk("no_byte_from_low_line", 64'(n_cerr), 64'd0);
    chk_idle_outputs("post_reset");
    foreach (tbl[v]) begin
      words = int'(tbl[v].size / 4);
      fill_data(tbl[v].d0, words > 1 ? words : 1);
      expect_cmd(tbl[v].op, tbl[v].addr, tbl[v].size);
      h0 = hs_cnt;
      if (tbl[v].stall > 0) bus.req_ready = 1'b0;
      send_cmd(tbl[v].op, tbl[v].addr, tbl[v].size);
      if (tbl[v].stall > 0) begin
        wait_valid($sformatf("vec%0d", v));
        tick(tbl[v].stall);
        h0 = hs_cnt;
        bus.req_ready = 1'b1;
        tick(words);
        chk($sformatf("vec%0d_back_to_back", v), 64'(hs_cnt - h0), 64'(words));
        h0 = h0 - tbl[v].exp_n + words;
        h0 = hs_cnt - words - (tbl[v].exp_n - words);
      end
      drain($sformatf("vec%0d", v));
      if (tbl[v].stall == 0) chk($sformatf("vec%0d_req_count", v), 64'(hs_cnt - h0), 64'(tbl[v].exp_n));
    end
    c0 = n_cerr;
    h0 = hs_cnt;
    send_byte(8'h41);
    tick(4);
    chk("bad_op_cmd_err", 64'(n_cerr - c0), 64'd1);
    fill_data(32'hA5A55A5A, 1);
    expect_cmd(TERM_OP_W, 32'h00000100, 0);
    send_cmd(TERM_OP_W, 32'h00000100, 0);
    drain("after_cmd_err");
    chk("after_cmd_err_count", 64'(hs_cnt - h0), 64'd1);
    f0 = n_ferr;
    h0 = hs_cnt;
    fill_data(32'h11223344, 1);
    expect_cmd(TERM_OP_W, 32'h0A0B0C0D, 0);
    send_byte(TERM_OP_W);
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h0C);
    send_byte(8'h0D);
    send_word(32'h11223344);
    drain("frame_mid_cmd");
    chk("frame_err_pulse", 64'(n_ferr - f0), 64'd1);
    chk("frame_mid_cmd_count", 64'(hs_cnt - h0), 64'd1);
    o0 = n_oerr;
    c0 = n_cerr;
    h0 = hs_cnt;
    bus.req_ready = 1'b0;
    fill_data(32'hCAFEF00D, 1);
    expect_cmd(TERM_OP_W, 32'hA0000000, 0);
    expect_cmd(TERM_OP_R, 32'hA0000010, 0);
    send_cmd(TERM_OP_W, 32'hA0000000, 0);
    wait_valid("overrun");
    send_byte(TERM_OP_R);
    send_byte(8'h00);
    tick(2);
    chk("overrun_pulse", 64'(n_oerr - o0), 64'd1);
    bus.req_ready = 1'b1;
    send_word(32'hA0000010);
    drain("overrun");
    chk("overrun_count", 64'(hs_cnt - h0), 64'd2);
    chk("overrun_no_cmd_err", 64'(n_cerr - c0), 64'd0);
    bus.req_ready = 1'b0;
    fill_data(32'h0BADF00D, 1);
    expect_cmd(TERM_OP_W, 32'h00000040, 0);
    send_cmd(TERM_OP_W, 32'h00000040, 0);
    wait_valid("rst_inflight");
    pulse_reset();
    chk_idle_outputs("rst_inflight");
    tick(2);
    rst = 1'b0;
    bus.req_ready = 1'b1;
    tick(20);
    send_byte(TERM_OP_J);
    send_word(32'h00002000);
    send_word(32'h00000008);
    send_byte(8'h77);
    send_byte(8'h88);
    pulse_reset();
    chk_idle_outputs("rst_mid_j");
    tick(2);
    rst = 1'b0;
    tick(20);
    h0 = hs_cnt;
    fill_data(32'h0, 1);
    expect_cmd(TERM_OP_R, 32'h00003000, 0);
    send_cmd(TERM_OP_R, 32'h00003000, 0);
    drain("after_rst");
    chk("after_rst_count", 64'(hs_cnt - h0), 64'd1);
    for (int r = 0; r < 5; r++) begin
      op = ops[$urandom_range(0, 3)];
      addr = $urandom;
      size = 32'($urandom_range(0, 20));
      fill_data($urandom, 6);
      expect_cmd(op, addr, size);
      words = exp_q.size();
      h0 = hs_cnt;
      send_cmd(op, addr, size);
      drain($sformatf("rand%0d", r));
      chk($sformatf("rand%0d_count", r), 64'(hs_cnt - h0), 64'(words));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
